// File: rtl/apb_exe_master.sv
// APB requester for the execution-unit register front-end.
// Each start runs a fixed sequence: write A, B and OPER, then read RESULT and STATUS.
//   state  | meaning
//   IDLE   | waiting for i_start, no APB activity
//   SETUP  | APB setup phase of the current transfer
//   ACCESS | APB access phase, waiting for pready or timeout
//   DONE   | one-cycle completion pulse
module apb_exe_master #(
    parameter int MBIT    = 4,
    parameter int NBIT    = 2,
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            i_clk,
    input  logic            i_rsn,
    input  logic            i_start,
    input  logic [MBIT-1:0] i_argA,
    input  logic [MBIT-1:0] i_argB,
    input  logic [NBIT-1:0] i_oper,
    output logic            o_busy,
    output logic            o_done,
    output logic [1:0]      o_err,
    output logic [MBIT-1:0] o_result,
    output logic [3:0]      o_status,
    output logic [AW-1:0]   o_paddr,
    output logic            o_psel,
    output logic            o_penable,
    output logic            o_pwrite,
    output logic [DW-1:0]   o_pwdata,
    input  logic [DW-1:0]   i_prdata,
    input  logic            i_pready,
    input  logic            i_pslverr
);

    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t          state;
    logic [2:0]      idx;
    logic [CW-1:0]   wait_cnt;
    logic [MBIT-1:0] arg_a;
    logic [MBIT-1:0] arg_b;
    logic [NBIT-1:0] oper;
    logic [2:0]      idx_next;

    // Upper read-data bits beyond the result/status fields carry no meaning.
    logic unused_prdata;
    assign unused_prdata = ^i_prdata;

    assign idx_next = idx + 3'd1;

    function automatic logic [AW-1:0] xfer_addr(input logic [2:0] i);
        return AW'({i, 2'b00});
    endfunction

    function automatic logic [DW-1:0] xfer_wdata(input logic [2:0] i,
                                                 input logic [MBIT-1:0] a,
                                                 input logic [MBIT-1:0] b,
                                                 input logic [NBIT-1:0] op);
        case (i)
            3'd0:    return DW'(a);
            3'd1:    return DW'(b);
            3'd2:    return DW'(op);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge i_clk or negedge i_rsn) begin
        if (!i_rsn) begin
            state     <= IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            arg_a     <= '0;
            arg_b     <= '0;
            oper      <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 2'b00;
            o_result  <= '0;
            o_status  <= '0;
            o_paddr   <= '0;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_pwrite  <= 1'b0;
            o_pwdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        arg_a     <= i_argA;
                        arg_b     <= i_argB;
                        oper      <= i_oper;
                        idx       <= 3'd0;
                        o_busy    <= 1'b1;
                        o_err     <= 2'b00;
                        o_psel    <= 1'b1;
                        o_penable <= 1'b0;
                        o_paddr   <= xfer_addr(3'd0);
                        o_pwrite  <= 1'b1;
                        o_pwdata  <= xfer_wdata(3'd0, i_argA, i_argB, i_oper);
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    // Down-counter: terminal count 0 marks the last allowed wait cycle.
                    wait_cnt  <= CW'(TIMEOUT - 1);
                    o_penable <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (i_pready) begin
                        if (i_pslverr) begin
                            o_err     <= 2'b01;
                            o_psel    <= 1'b0;
                            o_penable <= 1'b0;
                            o_done    <= 1'b1;
                            state     <= DONE;
                        end else begin
                            if (idx == 3'd3) o_result <= i_prdata[MBIT-1:0];
                            if (idx == 3'd4) o_status <= i_prdata[3:0];
                            if (idx == 3'd4) begin
                                o_err     <= 2'b00;
                                o_psel    <= 1'b0;
                                o_penable <= 1'b0;
                                o_done    <= 1'b1;
                                state     <= DONE;
                            end else begin
                                idx       <= idx_next;
                                o_penable <= 1'b0;
                                o_paddr   <= xfer_addr(idx_next);
                                o_pwrite  <= (idx_next < 3'd3);
                                o_pwdata  <= xfer_wdata(idx_next, arg_a, arg_b, oper);
                                state     <= SETUP;
                            end
                        end
                    end else if (wait_cnt == '0) begin
                        o_err     <= 2'b10;
                        o_psel    <= 1'b0;
                        o_penable <= 1'b0;
                        o_done    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
